// File: rtl/midi_note_parser_pkg.sv
// Shared constants and byte classification for the MIDI note parser.
package midi_note_parser_pkg;

  localparam int         B9600       = 1250;
  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [7:0] SYS_BASE    = 8'hF0;
  localparam logic [7:0] RT_BASE     = 8'hF8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_D1   = 2'd1;
  localparam logic [1:0] S_D2   = 2'd2;
  localparam logic [1:0] S_SKIP = 2'd3;

  typedef enum logic [1:0] {
    BYTE_DATA,
    BYTE_CHAN,
    BYTE_SYS,
    BYTE_RT
  } byte_class_e;

  function automatic byte_class_e classify(input logic [7:0] b);
    if (!b[7])             return BYTE_DATA;
    else if (b < SYS_BASE) return BYTE_CHAN;
    else if (b < RT_BASE)  return BYTE_SYS;
    else                   return BYTE_RT;
  endfunction

endpackage

// File: rtl/midi_note_parser_if.sv
// Byte input and note-event output bundle of the MIDI note parser.
interface midi_note_parser_if;
  logic        rcv;
  logic [7:0]  data;
  logic        note_valid;
  logic        note_on;
  logic [6:0]  note;
  logic [3:0]  channel;
  logic [3:0]  amp;
  logic [15:0] frec;
  logic        gate;

  modport master (
    output rcv, data,
    input  note_valid, note_on, note, channel, amp, frec, gate
  );

  modport slave (
    input  rcv, data,
    output note_valid, note_on, note, channel, amp, frec, gate
  );
endinterface

// File: rtl/midi_note_parser_byte_timeout.sv
// Saturating inter-byte idle counter; expired stays high until restarted.
module byte_timeout #(
  parameter int TIMEOUT = 37500
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic expired_o
);
  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i)           cnt_d = '0;
    else if (cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);
endmodule

// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser: Note-On/Off with running status to registered note events.
module midi_note_parser
  import midi_note_parser_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b0,
  parameter int         TIMEOUT = 37500
) (
  input logic               clk,
  input logic               reset,
  midi_note_parser_if.slave midi
);
  logic [1:0]  state_q, state_d;
  logic [7:0]  rs_status_q, rs_status_d;
  logic [6:0]  note_r_q, note_r_d;
  logic [6:0]  held_note_q, held_note_d;
  logic        note_valid_q, note_valid_d;
  logic        note_on_q, note_on_d;
  logic [6:0]  note_q, note_d;
  logic [3:0]  channel_q, channel_d;
  logic [3:0]  amp_q, amp_d;
  logic [15:0] frec_q, frec_d;
  logic        gate_q, gate_d;

  byte_class_e cls;
  logic        byte_in;
  logic        expired;
  logic        fire;
  logic        accept;
  logic        evt_on;
  logic [6:0]  vel;

  assign cls     = classify(midi.data);
  assign byte_in = midi.rcv && (cls != BYTE_RT);
  assign vel     = midi.data[6:0];
  assign accept  = OMNI || (rs_status_q[3:0] == CHANNEL);
  assign evt_on  = rs_status_q[4] && (vel != 7'd0);

  byte_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .restart_i(byte_in),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    rs_status_d = rs_status_q;
    note_r_d    = note_r_q;
    fire        = 1'b0;
    if (byte_in) begin
      case (cls)
        BYTE_CHAN: begin
          rs_status_d = midi.data;
          state_d     = (midi.data[7:4] == ST_NOTE_OFF || midi.data[7:4] == ST_NOTE_ON)
                        ? S_D1 : S_SKIP;
        end
        BYTE_SYS: begin
          rs_status_d = 8'h00;
          state_d     = S_IDLE;
        end
        BYTE_DATA: begin
          if (state_q == S_D1) begin
            note_r_d = vel;
            state_d  = S_D2;
          end else if (state_q == S_D2) begin
            fire    = 1'b1;
            state_d = S_D1;
          end
        end
        default: ;
      endcase
    end else if (expired && state_q == S_D2) begin
      // Partial note dropped, but running status survives the gap.
      state_d = S_D1;
    end
  end

  always_comb begin
    note_valid_d = 1'b0;
    note_on_d    = note_on_q;
    note_d       = note_q;
    channel_d    = channel_q;
    amp_d        = amp_q;
    frec_d       = frec_q;
    gate_d       = gate_q;
    held_note_d  = held_note_q;
    if (fire && accept) begin
      note_valid_d = 1'b1;
      note_on_d    = evt_on;
      note_d       = note_r_q;
      channel_d    = rs_status_q[3:0];
      amp_d        = evt_on ? vel[6:3] : 4'd0;
      frec_d       = 16'd1 << note_r_q[6:3];
      if (evt_on) begin
        gate_d      = 1'b1;
        held_note_d = note_r_q;
      end else if (note_r_q == held_note_q) begin
        gate_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rs_status_q  <= 8'h00;
      note_r_q     <= 7'd0;
      held_note_q  <= 7'd0;
      note_valid_q <= 1'b0;
      note_on_q    <= 1'b0;
      note_q       <= 7'd0;
      channel_q    <= 4'd0;
      amp_q        <= 4'd0;
      frec_q       <= 16'd0;
      gate_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rs_status_q  <= rs_status_d;
      note_r_q     <= note_r_d;
      held_note_q  <= held_note_d;
      note_valid_q <= note_valid_d;
      note_on_q    <= note_on_d;
      note_q       <= note_d;
      channel_q    <= channel_d;
      amp_q        <= amp_d;
      frec_q       <= frec_d;
      gate_q       <= gate_d;
    end
  end

  assign midi.note_valid = note_valid_q;
  assign midi.note_on    = note_on_q;
  assign midi.note       = note_q;
  assign midi.channel    = channel_q;
  assign midi.amp        = amp_q;
  assign midi.frec       = frec_q;
  assign midi.gate       = gate_q;
endmodule

// File: tb/tb_midi_note_parser.sv
// Scoreboard bench: channel-filtered DUT (a) and OMNI DUT (b) share one byte stream.
module tb_midi_note_parser;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rcv = 1'b0;
  logic [7:0] data = 8'h00;

  int checks = 0;
  int errs   = 0;

  logic [32:0] qa[$];
  logic [32:0] qb[$];

  midi_note_parser_if ifa ();
  midi_note_parser_if ifb ();

  assign ifa.rcv  = rcv;
  assign ifa.data = data;
  assign ifb.rcv  = rcv;
  assign ifb.data = data;

  midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b0), .TIMEOUT(TMO)) dut_a (
    .clk(clk), .reset(reset), .midi(ifa)
  );
  midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b1), .TIMEOUT(TMO)) dut_b (
    .clk(clk), .reset(reset), .midi(ifb)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] pk(input logic on, input logic [6:0] n, input logic [3:0] ch,
                                     input logic [3:0] a, input logic [15:0] f, input logic g);
    return {on, n, ch, a, f, g};
  endfunction

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rcv  = 1'b1;
    data = b;
    @(negedge clk);
    rcv  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic push_both(input logic [32:0] e);
    qa.push_back(e);
    qb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (ifa.note_valid) begin
      if (qa.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_a: got note=%0d ch=%0d expected no event", ifa.note, ifa.channel);
      end else begin
        chk("evt_a", {1'b0, ifa.note_on, ifa.note, ifa.channel, ifa.amp, ifa.frec, ifa.gate},
            {1'b0, qa.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.note_valid) begin
      if (qb.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_b: got note=%0d ch=%0d expected no event", ifb.note, ifb.channel);
      end else begin
        chk("evt_b", {1'b0, ifb.note_on, ifb.note, ifb.channel, ifb.amp, ifb.frec, ifb.gate},
            {1'b0, qb.pop_front()});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    idle(2);
    reset = 1'b0;
    chk("rst_a", {ifa.note_valid, ifa.note_on, ifa.note, ifa.channel, ifa.amp, ifa.frec, ifa.gate}, 34'd0);
    chk("rst_b", {ifb.note_valid, ifb.note_on, ifb.note, ifb.channel, ifb.amp, ifb.frec, ifb.gate}, 34'd0);

    // Basic Note-On
    push_both(pk(1'b1, 7'd60, 4'd0, 4'hC, 16'h0080, 1'b1));
    send(8'h90); send(8'h3C); send(8'h64);
    idle(2);

    // Running status
    do_reset();
    push_both(pk(1'b1, 7'd64, 4'd0, 4'hA, 16'h0100, 1'b1));
    push_both(pk(1'b1, 7'd67, 4'd0, 4'h4, 16'h0100, 1'b1));
    send(8'h90); send(8'h40); send(8'h50); send(8'h43); send(8'h20);
    idle(2);

    // Note-On velocity 0 acts as Note-Off for the held note
    do_reset();
    push_both(pk(1'b1, 7'd60, 4'd0, 4'hC, 16'h0080, 1'b1));
    push_both(pk(1'b0, 7'd60, 4'd0, 4'h0, 16'h0080, 1'b0));
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3C); send(8'h00);
    idle(2);

    // Note-Off for a different note keeps gate
    do_reset();
    push_both(pk(1'b1, 7'd60, 4'd0, 4'hC, 16'h0080, 1'b1));
    push_both(pk(1'b0, 7'd61, 4'd0, 4'h0, 16'h0080, 1'b1));
    send(8'h90); send(8'h3C); send(8'h64); send(8'h80); send(8'h3D); send(8'h40);
    idle(2);

    // Real-time byte inside a message
    do_reset();
    push_both(pk(1'b1, 7'd60, 4'd0, 4'hC, 16'h0080, 1'b1));
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    idle(2);

    // Foreign channel: filtered by a, accepted by b
    do_reset();
    push_both(pk(1'b1, 7'd60, 4'd0, 4'hC, 16'h0080, 1'b1));
    qb.push_back(pk(1'b1, 7'd60, 4'd1, 4'hC, 16'h0080, 1'b1));
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h91); send(8'h3C); send(8'h64);
    idle(2);
    chk("hold_a", {ifa.note_valid, ifa.note_on, ifa.note, ifa.channel, ifa.amp, ifa.frec, ifa.gate},
        {1'b0, pk(1'b1, 7'd60, 4'd0, 4'hC, 16'h0080, 1'b1)});

    // System common clears running status; non-note statuses skip their data
    do_reset();
    push_both(pk(1'b1, 7'd60, 4'd0, 4'hC, 16'h0080, 1'b1));
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'hF2); send(8'h3C); send(8'h64);
    send(8'hB0); send(8'h07); send(8'h64);
    send(8'hC0); send(8'h05); send(8'h3C); send(8'h64);
    push_both(pk(1'b1, 7'd80, 4'd0, 4'h8, 16'h0400, 1'b1));
    send(8'h90); send(8'h50); send(8'h40);
    idle(2);

    // Gap shorter than the timeout keeps the partial note
    do_reset();
    push_both(pk(1'b1, 7'd60, 4'd0, 4'hC, 16'h0080, 1'b1));
    send(8'h90); send(8'h3C);
    idle(TMO - 5);
    send(8'h64);
    idle(2);

    // Timeout in D2 drops the note but keeps running status
    do_reset();
    push_both(pk(1'b1, 7'd80, 4'd0, 4'h8, 16'h0400, 1'b1));
    send(8'h90); send(8'h3C);
    idle(TMO + 1);
    send(8'h50); send(8'h40);
    idle(2);

    // Reset mid-message discards it and drops gate
    do_reset();
    push_both(pk(1'b1, 7'd60, 4'd0, 4'hC, 16'h0080, 1'b1));
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    idle(3);
    chk("mid_rst_a", {ifa.note_valid, ifa.note_on, ifa.note, ifa.channel, ifa.amp, ifa.frec, ifa.gate}, 34'd0);
    chk("mid_rst_b", {ifb.note_valid, ifb.note_on, ifb.note, ifb.channel, ifb.amp, ifb.frec, ifb.gate}, 34'd0);

    idle(3);
    chk("pending_a", 34'(qa.size()), 34'd0);
    chk("pending_b", 34'(qb.size()), 34'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
